// File: rtl/timer_pkg.sv
// Shared types and constants for the TIMER custom-instruction peripheral.
// The optional preload behaviour is selected by the TIMER_PRELOAD_EN macro in timer_unit.
package timer_pkg;

   localparam int unsigned CNT_W_DEF    = 32;
   localparam logic [6:0]  TIMER_OPCODE = 7'b0100101;

   typedef enum logic [2:0] {
      TIM_ENABLE  = 3'b000,
      TIM_PSC_I   = 3'b001,
      TIM_ARR_I   = 3'b010,
      TIM_CLEAR   = 3'b011,
      TIM_PSC_REG = 3'b100,
      TIM_ARR_REG = 3'b101,
      TIM_RSVD    = 3'b110,
      TIM_DISABLE = 3'b111
   } timer_cmd_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler stage: counts run cycles and emits a tick when psc_cnt reaches psc.
// clr zeroes the count and masks the tick for that cycle.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] psc,
   input  logic             run,
   input  logic             clr,
   output logic             tick
);

   logic [CNT_W-1:0] r_psc_cnt;
   logic             w_wrap;

   assign w_wrap = (r_psc_cnt >= psc);
   assign tick   = run && w_wrap && !clr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_psc_cnt <= '0;
      end else if (clr) begin
         r_psc_cnt <= '0;
      end else if (run) begin
         if (w_wrap) r_psc_cnt <= '0;
         else        r_psc_cnt <= r_psc_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/timer_unit.sv
// TIMER instruction executor: prescaled auto-reload up-counter with overflow flag/pulse.
// Define TIMER_PRELOAD_EN to route PSC/ARR writes through shadow registers.
module timer_unit
   import timer_pkg::*;
#(
   parameter int unsigned      CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] ARR_RST = {CNT_W{1'b1}},
   parameter logic [CNT_W-1:0] PSC_RST = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic [2:0]       funct3,
   input  logic [CNT_W-1:0] operand,
   output logic [CNT_W-1:0] cnt_out,
   output logic             running,
   output logic             ovf_flag,
   output logic             ovf_pulse
);

   timer_state_e     r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_psc;
   logic [CNT_W-1:0] r_arr;
   logic             r_ovf_flag;
   logic             r_ovf_pulse;

   timer_cmd_e w_cmd;
   logic       w_en, w_dis, w_clr, w_psc_wr, w_arr_wr;
   logic       w_run, w_tick, w_upd;

   assign w_cmd    = timer_cmd_e'(funct3);
   assign w_en     = cmd_valid && (w_cmd == TIM_ENABLE);
   assign w_dis    = cmd_valid && (w_cmd == TIM_DISABLE);
   assign w_clr    = cmd_valid && (w_cmd == TIM_CLEAR);
   assign w_psc_wr = cmd_valid && ((w_cmd == TIM_PSC_I) || (w_cmd == TIM_PSC_REG));
   assign w_arr_wr = cmd_valid && ((w_cmd == TIM_ARR_I) || (w_cmd == TIM_ARR_REG));

   // A DISABLE freezes both counters in the cycle it arrives.
   assign w_run = (r_state == RUN) && !w_dis;
   assign w_upd = w_tick && (r_cnt >= r_arr);

   timer_prescaler #(
      .CNT_W (CNT_W)
   ) u_psc (
      .clk   (clk),
      .reset (reset),
      .psc   (r_psc),
      .run   (w_run),
      .clr   (w_clr),
      .tick  (w_tick)
   );

`ifdef TIMER_PRELOAD_EN
   logic [CNT_W-1:0] r_psc_sh;
   logic [CNT_W-1:0] r_arr_sh;
   logic             w_load;

   assign w_load = w_upd || w_clr || (w_en && (r_state == IDLE));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_psc_sh <= PSC_RST;
         r_arr_sh <= ARR_RST;
         r_psc    <= PSC_RST;
         r_arr    <= ARR_RST;
      end else begin
         if (w_psc_wr) r_psc_sh <= operand;
         if (w_arr_wr) r_arr_sh <= operand;
         if (w_load) begin
            r_psc <= r_psc_sh;
            r_arr <= r_arr_sh;
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (reset) begin
         r_psc <= PSC_RST;
         r_arr <= ARR_RST;
      end else begin
         if (w_psc_wr) r_psc <= operand;
         if (w_arr_wr) r_arr <= operand;
      end
   end
`endif

   // FSM, counter and overflow flags; CLEAR outranks a coincident update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_ovf_flag  <= 1'b0;
         r_ovf_pulse <= 1'b0;
      end else begin
         r_ovf_pulse <= w_upd;
         case (r_state)
            IDLE:    if (w_en)  r_state <= RUN;
            RUN:     if (w_dis) r_state <= IDLE;
            default:            r_state <= IDLE;
         endcase
         if (w_clr) begin
            r_cnt      <= '0;
            r_ovf_flag <= 1'b0;
         end else if (w_upd) begin
            r_cnt      <= '0;
            r_ovf_flag <= 1'b1;
         end else if (w_tick) begin
            r_cnt      <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign cnt_out   = r_cnt;
   assign running   = (r_state == RUN);
   assign ovf_flag  = r_ovf_flag;
   assign ovf_pulse = r_ovf_pulse;

endmodule
